// File: rtl/serial_loader_pkg.sv
// rtl/serial_loader_pkg.sv - shared types and constants for the serial byte loader
// Contents: state_e (IDLE/SHIFT), synchronizer depth limits, counter width helper.
package serial_loader_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int SYNC_MIN   = 2;
  localparam int SYNC_MAX   = 4;
  localparam int DEF_WIDTH  = 8;
  localparam int DEF_CNT_W  = $clog2(DEF_WIDTH);

  // Bit counter width for a given word size; never narrower than one bit.
  function automatic int cnt_width(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/sync_bit.sv
// rtl/sync_bit.sv - multi-flop synchronizer for one asynchronous input bit
// Ports: clk/rst (sync, active-high), d (async in), q (synchronized out).
module sync_bit #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_q;
  logic [STAGES-1:0] chain_d;

  assign chain_d = {chain_q[STAGES-2:0], d};
  assign q       = chain_q[STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) chain_q <= {STAGES{RESET_VAL}};
    else     chain_q <= chain_d;
  end

endmodule

// File: rtl/serial_byte_loader.sv
// rtl/serial_byte_loader.sv - SPI mode-0 style serial-to-parallel word loader
// Ports: clk, rst (sync, active-high); sclk_in, sdi_in, cs_n_in (async serial pins);
//        dout (last word), dout_en (1-cycle new-word strobe),
//        frame_err (1-cycle partial-word abort pulse), busy (in SHIFT).
module serial_byte_loader
  import serial_loader_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter bit MSB_FIRST   = 1'b1,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sclk_in,
  input  logic             sdi_in,
  input  logic             cs_n_in,
  output logic [WIDTH-1:0] dout,
  output logic             dout_en,
  output logic             frame_err,
  output logic             busy
);

  localparam int CNT_W = cnt_width(WIDTH);

  if (SYNC_STAGES < SYNC_MIN || SYNC_STAGES > SYNC_MAX) begin : g_bad_stages
    $error("serial_byte_loader: SYNC_STAGES out of range");
  end

  logic sclk_s, sdi_s, cs_s;

  sync_bit #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .d(sclk_in), .q(sclk_s));
  sync_bit #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sdi (
    .clk(clk), .rst(rst), .d(sdi_in), .q(sdi_s));
  sync_bit #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst(rst), .d(cs_n_in), .q(cs_s));

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             en_q, en_d;
  logic             err_q, err_d;
  logic             sclk_d1_q, cs_d1_q;
  logic [2:0]       flush_q, flush_d;
  logic             arm_q, arm_d;

  logic             flushed;
  logic             sclk_rise, cs_fall, cs_rise;
  logic [WIDTH-1:0] shifted;

  // Edges are suppressed until the synchronizers hold post-reset samples only.
  assign flushed   = (flush_q == 3'(SYNC_STAGES));
  assign sclk_rise = flushed & sclk_s & ~sclk_d1_q;
  assign cs_rise   = flushed & cs_s & ~cs_d1_q;
  // arm_q only sets after cs_n was seen high, so a pin held low through reset never opens a frame.
  assign cs_fall   = flushed & arm_q & ~cs_s & cs_d1_q;

  assign shifted = MSB_FIRST ? {shift_q[WIDTH-2:0], sdi_s} : {sdi_s, shift_q[WIDTH-1:1]};

  assign flush_d = flushed ? flush_q : flush_q + 3'd1;
  assign arm_d   = arm_q | (flushed & cs_s);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    dout_d  = dout_q;
    en_d    = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d = SHIFT;
          cnt_d   = '0;
          shift_d = '0;
        end
      end
      SHIFT: begin
        // cs_n rise has priority; a coincident sclk rise is dropped.
        if (cs_rise) begin
          state_d = IDLE;
          err_d   = (cnt_q != '0);
          cnt_d   = '0;
          shift_d = '0;
        end else if (sclk_rise) begin
          shift_d = shifted;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            dout_d = shifted;
            en_d   = 1'b1;
            cnt_d  = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      dout_q    <= '0;
      en_q      <= 1'b0;
      err_q     <= 1'b0;
      sclk_d1_q <= 1'b0;
      cs_d1_q   <= 1'b1;
      flush_q   <= '0;
      arm_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      dout_q    <= dout_d;
      en_q      <= en_d;
      err_q     <= err_d;
      sclk_d1_q <= sclk_s;
      cs_d1_q   <= cs_s;
      flush_q   <= flush_d;
      arm_q     <= arm_d;
    end
  end

  assign dout      = dout_q;
  assign dout_en   = en_q;
  assign frame_err = err_q;
  assign busy      = (state_q == SHIFT);

endmodule

// File: tb/tb_serial_byte_loader.sv
// tb/tb_serial_byte_loader.sv - directed self-checking bench for serial_byte_loader
module tb_serial_byte_loader;

  logic clk = 1'b0;
  logic rst, sclk_in, sdi_in, cs_n_in;
  logic [7:0] dout_m, dout_l;
  logic en_m, en_l, err_m, err_l, busy_m, busy_l;

  int checks = 0;
  int errors = 0;
  int en_cnt_m = 0, en_cnt_l = 0, err_cnt_m = 0, err_cnt_l = 0, overlap = 0;
  logic [7:0] log_m [0:15];
  int log_n = 0;

  always #5 clk = ~clk;

  serial_byte_loader #(.WIDTH(8), .MSB_FIRST(1'b1), .SYNC_STAGES(2)) dut_m (
    .clk(clk), .rst(rst), .sclk_in(sclk_in), .sdi_in(sdi_in), .cs_n_in(cs_n_in),
    .dout(dout_m), .dout_en(en_m), .frame_err(err_m), .busy(busy_m));

  serial_byte_loader #(.WIDTH(8), .MSB_FIRST(1'b0), .SYNC_STAGES(2)) dut_l (
    .clk(clk), .rst(rst), .sclk_in(sclk_in), .sdi_in(sdi_in), .cs_n_in(cs_n_in),
    .dout(dout_l), .dout_en(en_l), .frame_err(err_l), .busy(busy_l));

  // Counts high cycles of each strobe; strobes are far apart, so high cycles == pulses of width 1.
  always @(negedge clk) begin
    if (en_m === 1'b1) begin
      en_cnt_m <= en_cnt_m + 1;
      if (log_n < 16) log_m[log_n] <= dout_m;
      log_n <= log_n + 1;
    end
    if (en_l === 1'b1) en_cnt_l <= en_cnt_l + 1;
    if (err_m === 1'b1) err_cnt_m <= err_cnt_m + 1;
    if (err_l === 1'b1) err_cnt_l <= err_cnt_l + 1;
    if ((en_m & err_m) === 1'b1 || (en_l & err_l) === 1'b1) overlap <= overlap + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    sdi_in = b;
    tick(4);
    sclk_in = 1'b1;
    tick(4);
    sclk_in = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w, input int nbits);
    for (int i = 7; i > 7 - nbits; i--) send_bit(w[i]);
    tick(4);
  endtask

  int base_en, base_err;

  initial begin
    rst = 1'b1; sclk_in = 1'b0; sdi_in = 1'b0; cs_n_in = 1'b1;
    tick(3);
    chk("reset_dout", dout_m, 8'h00);
    chk("reset_en", {en_m, en_l}, 2'b00);
    chk("reset_err", {err_m, err_l}, 2'b00);
    chk("reset_busy", {busy_m, busy_l}, 2'b00);
    rst = 1'b0;
    tick(8);

    // A5 frame, with latency check on the final bit
    cs_n_in = 1'b0;
    tick(6);
    chk("busy_in_frame", {busy_m, busy_l}, 2'b11);
    send_word(8'hA5, 7);
    sdi_in = 1'b1;
    tick(4);
    sclk_in = 1'b1;
    tick(2);
    chk("latency_early", en_m, 1'b0);
    tick(1);
    chk("latency_edge3", {en_m, en_l}, 2'b11);
    tick(5);
    sclk_in = 1'b0;
    tick(4);
    cs_n_in = 1'b1;
    tick(8);
    chk("a5_en_count", en_cnt_m, 1);
    chk("a5_dout_msb", dout_m, 8'hA5);
    chk("a5_dout_lsb", dout_l, 8'hA5);
    chk("a5_busy_drop", {busy_m, busy_l}, 2'b00);
    chk("a5_no_err", err_cnt_m + err_cnt_l, 0);

    // partial frame of 5 bits
    base_en = en_cnt_m; base_err = err_cnt_m;
    cs_n_in = 1'b0;
    tick(6);
    send_word(8'hF8, 5);
    cs_n_in = 1'b1;
    tick(8);
    chk("partial_err", err_cnt_m - base_err, 1);
    chk("partial_err_lsb", err_cnt_l, 1);
    chk("partial_no_en", en_cnt_m - base_en, 0);
    chk("partial_dout_kept", dout_m, 8'hA5);

    // back-to-back 3C, C3 in one frame
    base_en = en_cnt_m;
    cs_n_in = 1'b0;
    tick(6);
    send_word(8'h3C, 8);
    tick(6);
    chk("b2b_first_dout", dout_m, 8'h3C);
    chk("b2b_first_held_busy", busy_m, 1'b1);
    send_word(8'hC3, 8);
    cs_n_in = 1'b1;
    tick(8);
    chk("b2b_en_count", en_cnt_m - base_en, 2);
    chk("b2b_log0", log_m[1], 8'h3C);
    chk("b2b_log1", log_m[2], 8'hC3);
    chk("b2b_dout_lsb", dout_l, 8'hC3);

    // bit order distinguishes instances
    cs_n_in = 1'b0;
    tick(6);
    send_word(8'h01, 8);
    cs_n_in = 1'b1;
    tick(8);
    chk("order_msb", dout_m, 8'h01);
    chk("order_lsb", dout_l, 8'h80);

    // cs_n rise coincident with the 8th sclk rise
    base_en = en_cnt_m; base_err = err_cnt_m;
    cs_n_in = 1'b0;
    tick(6);
    send_word(8'hFF, 7);
    sdi_in = 1'b1;
    tick(4);
    sclk_in = 1'b1;
    cs_n_in = 1'b1;
    tick(8);
    sclk_in = 1'b0;
    tick(6);
    chk("coinc_err", err_cnt_m - base_err, 1);
    chk("coinc_no_en", en_cnt_m - base_en, 0);
    chk("coinc_dout_kept", {dout_m, dout_l}, 16'h0180);
    chk("coinc_idle", busy_m, 1'b0);

    // reset mid-frame with cs_n held low
    base_en = en_cnt_m; base_err = err_cnt_m;
    cs_n_in = 1'b0;
    tick(6);
    send_word(8'hE0, 3);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("midrst_dout", {dout_m, dout_l}, 16'h0000);
    chk("midrst_busy", {busy_m, busy_l}, 2'b00);
    send_word(8'hFF, 8);
    tick(4);
    chk("midrst_no_en", en_cnt_m - base_en, 0);
    chk("midrst_no_err", err_cnt_m - base_err, 0);
    chk("midrst_idle", busy_m, 1'b0);
    cs_n_in = 1'b1;
    tick(8);
    cs_n_in = 1'b0;
    tick(6);
    send_word(8'h81, 8);
    cs_n_in = 1'b1;
    tick(8);
    chk("after_rst_dout_msb", dout_m, 8'h81);
    chk("after_rst_dout_lsb", dout_l, 8'h81);
    chk("after_rst_en", en_cnt_m - base_en, 1);
    chk("total_en_lsb", en_cnt_l, en_cnt_m);
    chk("no_en_err_overlap", overlap, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
